// File: rtl/onc_16_loader_if.sv
// Byte-stream input and imem write port shared by the ONC-16 boot loader and its neighbours.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready from the loader throttles the byte stream; the imem port has none.
interface onc_16_loader_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [INST_W-1:0] imem_wdata;

    // Stream source / imem observer side.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );

    // Loader side.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );
endinterface

// File: rtl/onc_16_loader.sv
// Boot loader: big-endian byte stream -> 16-bit imem words from address 0; holds the core in reset until loaded.
// Latency: imem write one cycle after the INST_LO transfer; cpu_n_rst rises one cycle after DONE is entered.
// Backpressure: in_ready=1 while loading, 0 in DONE/ERR; optional checksum byte via ONC16_LOADER_CHECKSUM_EN.
module onc_16_loader #(
    parameter int INST_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 4096
) (
    input  logic           clock,
    input  logic           rst,
    input  logic           start,
    onc_16_loader_if.slave bus,
    output logic           cpu_n_rst,
    output logic           done,
    output logic           err
);
    // One spare bit so a count equal to a full address space cannot alias to zero.
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [2:0] S_LEN_HI  = 3'd0;
    localparam logic [2:0] S_LEN_LO  = 3'd1;
    localparam logic [2:0] S_DATA_HI = 3'd2;
    localparam logic [2:0] S_DATA_LO = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;
`ifdef ONC16_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM    = 3'd4;
    // Where the FSM goes once the last word (or an empty image) has been taken.
    localparam logic [2:0] S_TAIL    = S_CSUM;
`else
    localparam logic [2:0] S_TAIL    = S_DONE;
`endif

    logic [2:0]        state_q;
    logic [2:0]        state_nx;
    logic [7:0]        len_hi_q;
    logic [7:0]        inst_hi_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [15:0]       len_full;
    logic [INST_W-1:0] word;
    logic              xfer;
    logic              last_word;
`ifdef ONC16_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;
`endif

    assign xfer      = bus.in_valid & bus.in_ready;
    assign len_full  = {len_hi_q, bus.in_data};
    assign word      = INST_W'({inst_hi_q, bus.in_data});
    assign last_word = (cnt_q + CNT_W'(1)) == len_q;

    // Next-state decode; only an accepted byte moves the FSM.
    always_comb begin
        state_nx = state_q;
        if (xfer) begin
            case (state_q)
                S_LEN_HI:  state_nx = S_LEN_LO;
                S_LEN_LO: begin
                    if ({16'd0, len_full} > 32'(MAX_WORDS))
                        state_nx = S_ERR;
                    else if (len_full == 16'd0)
                        state_nx = S_TAIL;
                    else
                        state_nx = S_DATA_HI;
                end
                S_DATA_HI: state_nx = S_DATA_LO;
                S_DATA_LO: state_nx = last_word ? S_TAIL : S_DATA_HI;
`ifdef ONC16_LOADER_CHECKSUM_EN
                S_CSUM:    state_nx = (bus.in_data == sum_q) ? S_DONE : S_ERR;
`endif
                default:   state_nx = state_q;
            endcase
        end
    end

    // State, registered outputs and datapath; rst beats start, start beats a same-cycle transfer.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q        <= S_LEN_HI;
            bus.in_ready   <= 1'b1;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= '0;
            bus.imem_wdata <= '0;
            cpu_n_rst      <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            len_hi_q       <= '0;
            inst_hi_q      <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
`ifdef ONC16_LOADER_CHECKSUM_EN
            sum_q          <= '0;
`endif
        end else if (start) begin
            // Abandon whatever was in flight; words already written are left in imem.
            state_q        <= S_LEN_HI;
            bus.in_ready   <= 1'b1;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= '0;
            cpu_n_rst      <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            len_q          <= '0;
            cnt_q          <= '0;
`ifdef ONC16_LOADER_CHECKSUM_EN
            sum_q          <= '0;
`endif
        end else begin
            state_q      <= state_nx;
            bus.in_ready <= (state_nx != S_DONE) && (state_nx != S_ERR);
            done         <= (state_nx == S_DONE);
            err          <= (state_nx == S_ERR);
            // Registered off the current state so the final imem write lands before the core wakes.
            cpu_n_rst    <= (state_q == S_DONE);
            bus.imem_we  <= 1'b0;
            if (bus.imem_we)
                bus.imem_waddr <= bus.imem_waddr + ADDR_W'(1);
            if (xfer) begin
                case (state_q)
                    S_LEN_HI:  len_hi_q  <= bus.in_data;
                    S_LEN_LO:  len_q     <= CNT_W'(len_full);
                    S_DATA_HI: inst_hi_q <= bus.in_data;
                    S_DATA_LO: begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_wdata <= word;
                        cnt_q          <= cnt_q + CNT_W'(1);
                    end
                    default: ;
                endcase
`ifdef ONC16_LOADER_CHECKSUM_EN
                if (state_q != S_CSUM)
                    sum_q <= sum_q + bus.in_data;
`endif
            end
        end
    end
endmodule

// File: tb/tb_onc_16_loader.sv
// Self-checking bench for onc_16_loader: directed loads plus randomized gapped images vs a stream-level model.
// Latency: n/a (testbench).
// Backpressure: drives in_valid with random gaps and honours in_ready.
module tb_onc_16_loader;
    typedef logic [7:0] bq_t[$];

    logic clock = 1'b0;
    logic rst;
    logic start;
    logic cpu_n_rst;
    logic done;
    logic err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] obs_w[$];
    logic [31:0] exp_w[$];
    bit          exp_done;
    int          exp_nacc;

    onc_16_loader_if #(.ADDR_W(16), .INST_W(16)) bus();

    onc_16_loader #(.INST_W(16), .ADDR_W(16), .MAX_WORDS(4096)) dut (
        .clock     (clock),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .cpu_n_rst (cpu_n_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    // Record every imem write as {addr, data}, sampled mid-cycle.
    always @(negedge clock) begin
        if (bus.imem_we === 1'b1)
            obs_w.push_back({bus.imem_waddr, bus.imem_wdata});
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream-level reference: what the image should write and how it should end.
    task automatic model(input bq_t img);
        int n;
        exp_w.delete();
        n = int'({img[0], img[1]});
        if (n > 4096) begin
            exp_done = 1'b0;
            exp_nacc = 2;
        end else begin
            for (int k = 0; k < n; k++)
                exp_w.push_back({16'(k), img[2 + 2 * k], img[3 + 2 * k]});
            exp_nacc = 2 + 2 * n;
`ifdef ONC16_LOADER_CHECKSUM_EN
            begin
                logic [7:0] s;
                s = 8'd0;
                for (int i = 0; i < exp_nacc; i++) s = s + img[i];
                exp_done = (img[exp_nacc] == s);
                exp_nacc = exp_nacc + 1;
            end
`else
            exp_done = 1'b1;
`endif
        end
    endtask

    function automatic bq_t add_csum(input bq_t img);
        bq_t r;
        r = img;
`ifdef ONC16_LOADER_CHECKSUM_EN
        begin
            logic [7:0] s;
            s = 8'd0;
            foreach (img[i]) s = s + img[i];
            r.push_back(s);
        end
`endif
        return r;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g;
        g = 0;
        if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                bus.in_data = 8'($urandom);
                @(negedge clock);
            end
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 20) begin
            @(negedge clock);
            g++;
        end
        if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_load(input bq_t img, input bit gaps, input bit do_start, input string tag);
        int g;
        model(img);
        if (do_start) pulse_start();
        obs_w.delete();
        for (int i = 0; i < exp_nacc; i++) send_byte(img[i], gaps);
        g = 0;
        while (!(done || err) && g < 20) begin
            @(negedge clock);
            g++;
        end
        check({tag, ":done"}, 32'(done), 32'(exp_done));
        check({tag, ":err"}, 32'(err), 32'(!exp_done));
        check({tag, ":in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, ":cpu_n_rst_entry"}, 32'(cpu_n_rst), 32'd0);
        @(negedge clock);
        check({tag, ":cpu_n_rst_after"}, 32'(cpu_n_rst), 32'(exp_done));
        check({tag, ":n_writes"}, 32'(obs_w.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++)
            if (i < obs_w.size()) check($sformatf("%s:w%0d", tag, i), obs_w[i], exp_w[i]);
        check({tag, ":waddr_end"}, 32'(bus.imem_waddr), 32'(exp_w.size()));
    endtask

    initial begin
        bq_t img;
        int  n;

        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clock);
        check("rst:in_ready",   32'(bus.in_ready),   32'd1);
        check("rst:imem_we",    32'(bus.imem_we),    32'd0);
        check("rst:imem_waddr", 32'(bus.imem_waddr), 32'd0);
        check("rst:imem_wdata", 32'(bus.imem_wdata), 32'd0);
        check("rst:cpu_n_rst",  32'(cpu_n_rst),      32'd0);
        check("rst:done",       32'(done),           32'd0);
        check("rst:err",        32'(err),            32'd0);
        rst = 1'b0;
        @(negedge clock);

        // Two-word image straight out of reset.
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        run_load(add_csum(img), 1'b0, 1'b0, "two_words");

        // start while in DONE drops the core back into reset.
        pulse_start();
        check("restart_done:cpu_n_rst", 32'(cpu_n_rst),      32'd0);
        check("restart_done:done",      32'(done),           32'd0);
        check("restart_done:in_ready",  32'(bus.in_ready),   32'd1);
        check("restart_done:waddr",     32'(bus.imem_waddr), 32'd0);

        // Empty image.
        img = '{8'h00, 8'h00};
        run_load(add_csum(img), 1'b0, 1'b1, "empty");

        // Oversize length: error, sticky until start even with bytes offered.
        img = '{8'h10, 8'h01};
        run_load(img, 1'b0, 1'b1, "oversize");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        repeat (4) @(negedge clock);
        bus.in_valid = 1'b0;
        check("oversize:err_sticky",  32'(err),           32'd1);
        check("oversize:cpu_n_rst",   32'(cpu_n_rst),     32'd0);
        check("oversize:no_writes",   32'(obs_w.size()),  32'd0);

`ifdef ONC16_LOADER_CHECKSUM_EN
        // Good and bad checksum on a one-word image.
        img = '{8'h00, 8'h01, 8'h12, 8'h34};
        run_load(add_csum(img), 1'b0, 1'b1, "csum_good");
        img = add_csum(img);
        img[4] = img[4] + 8'd1;
        run_load(img, 1'b1, 1'b1, "csum_bad");
`endif

        // Randomized images with gapped in_valid, including the 3-word case.
        for (int r = 0; r < 6; r++) begin
            n = (r < 2) ? 3 : int'($urandom_range(1, 6));
            img = '{8'(n >> 8), 8'(n)};
            for (int k = 0; k < 2 * n; k++) img.push_back(8'($urandom));
            run_load(add_csum(img), (r != 0), 1'b1, $sformatf("rand%0d", r));
        end

        // Largest legal image.
        img = '{8'h10, 8'h00};
        for (int k = 0; k < 8192; k++) img.push_back(8'($urandom));
        run_load(add_csum(img), 1'b0, 1'b1, "max_words");

        // Mid-load start with a colliding byte, then a fresh one-word image.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h12, 1'b0);
        start        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        @(negedge clock);
        start        = 1'b0;
        bus.in_valid = 1'b0;
        img = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        run_load(add_csum(img), 1'b0, 1'b0, "restart_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
